ftdi_pkt_arbiter: RTL

FTDI_PKT_ARBITER -- requirements
Module: ftdi_pkt_arbiter

---
 rtl/ftdi_pkg.sv | 33 +++
 rtl/ftdi_pkt_arbiter_counter.sv | 38 +++
 rtl/ftdi_pkt_arbiter.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/ftdi_pkg.sv
// ftdi_pkg
// Shared types and constants for the FTDI packet arbiter.
//   state_e   : arbiter FSM states
//   src_e     : grant / source encoding (NONE, CTRL, DATA)
//   MAX_PKT   : largest packet the FTDI 1k queue holds
//   len_decode: maps a 10-bit request length to an 11-bit byte count
package ftdi_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FILL  = 2'd1,
        S_LOAD  = 2'd2,
        S_GUARD = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        SRC_NONE = 2'b00,
        SRC_CTRL = 2'b01,
        SRC_DATA = 2'b10
    } src_e;

    localparam logic [10:0] MAX_PKT = 11'd1024;

    // A length of zero encodes a full 1024-byte packet.
    function automatic logic [10:0] len_decode(input logic [9:0] len);
        if (len == 10'd0) begin
            len_decode = MAX_PKT;
        end else begin
            len_decode = {1'b0, len};
        end
    endfunction

endpackage

// File: rtl/ftdi_pkt_arbiter_counter.sv
// ftdi_pkt_arbiter_counter
// Generic up-counter with synchronous clear (clear has priority over inc).
//   clock : system clock
//   clr   : synchronous clear to zero
//   inc   : increment by one
//   count : current count
module ftdi_pkt_arbiter_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Next-count selection.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc) begin
            count_d = count_q + WIDTH'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clock) begin
        count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/ftdi_pkt_arbiter.sv
// ftdi_pkt_arbiter
// Arbitrates two byte sources (control, data) into the FTDI 1k packet queue.
// One source is granted per packet; its bytes are forwarded with zero latency,
// the packet is committed with load_1k, and a guard interval follows before
// the next grant. A stalled packet is aborted after TIMEOUT idle cycles.
//   clock, reset, clear        : clock, sync active-high reset, sync soft clear
//   c_req/c_len/c_valid/c_data : control source request and byte stream
//   c_ready                    : control byte accepted
//   d_*                        : same for the data source
//   wrq_full                   : FTDI queue full
//   wrreq/data_wr              : queue write strobe and byte
//   load_1k/wr_clear           : packet commit / queue flush pulses
//   grant/busy/err_timeout     : status
module ftdi_pkt_arbiter
    import ftdi_pkg::*;
#(
    parameter int GUARD_CYCLES = 1100,
    parameter int TIMEOUT      = 256
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       clear,
    input  logic       c_req,
    input  logic [9:0] c_len,
    input  logic       c_valid,
    input  logic [7:0] c_data,
    output logic       c_ready,
    input  logic       d_req,
    input  logic [9:0] d_len,
    input  logic       d_valid,
    input  logic [7:0] d_data,
    output logic       d_ready,
    input  logic       wrq_full,
    output logic       wrreq,
    output logic [7:0] data_wr,
    output logic       load_1k,
    output logic       wr_clear,
    output logic [1:0] grant,
    output logic       busy,
    output logic       err_timeout
);

    localparam int GW = $clog2(GUARD_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    state_e      state_q, state_d;
    src_e        grant_q, grant_d;
    src_e        last_grant_q, last_grant_d;
    logic [10:0] len_q, len_d;
    logic        load_1k_q, load_1k_d;
    logic        wr_clear_q, wr_clear_d;
    logic        err_timeout_q, err_timeout_d;
    logic        busy_q, busy_d;

    logic          rst_s;
    logic          fill_s;
    logic          c_xfer_s;
    logic          d_xfer_s;
    logic          xfer_s;
    logic [10:0]   byte_cnt_s;
    logic [GW-1:0] guard_cnt_s;
    logic [TW-1:0] tout_cnt_s;

    assign rst_s  = reset | clear;
    assign fill_s = (state_q == S_FILL);

    // Ready is suppressed during reset/clear so no byte is taken that the
    // cleared state would forget.
    assign c_ready  = fill_s & (grant_q == SRC_CTRL) & ~wrq_full & ~rst_s;
    assign d_ready  = fill_s & (grant_q == SRC_DATA) & ~wrq_full & ~rst_s;
    assign c_xfer_s = c_ready & c_valid;
    assign d_xfer_s = d_ready & d_valid;
    assign xfer_s   = c_xfer_s | d_xfer_s;
    assign wrreq    = xfer_s;

    // Byte mux toward the queue; zero when nothing is written.
    always_comb begin
        data_wr = 8'd0;
        if (c_xfer_s) begin
            data_wr = c_data;
        end else if (d_xfer_s) begin
            data_wr = d_data;
        end else begin
            data_wr = 8'd0;
        end
    end

    ftdi_pkt_arbiter_counter #(.WIDTH(11)) u_byte_cnt (
        .clock (clock),
        .clr   (rst_s | ~fill_s),
        .inc   (xfer_s),
        .count (byte_cnt_s)
    );

    ftdi_pkt_arbiter_counter #(.WIDTH(GW)) u_guard_cnt (
        .clock (clock),
        .clr   (rst_s | (state_q != S_GUARD)),
        .inc   (1'b1),
        .count (guard_cnt_s)
    );

    // Counts consecutive non-transfer FILL cycles, including wrq_full stalls.
    ftdi_pkt_arbiter_counter #(.WIDTH(TW)) u_tout_cnt (
        .clock (clock),
        .clr   (rst_s | ~fill_s | xfer_s),
        .inc   (1'b1),
        .count (tout_cnt_s)
    );

    // Next-state and registered-output logic.
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        last_grant_d  = last_grant_q;
        len_d         = len_q;
        load_1k_d     = 1'b0;
        wr_clear_d    = 1'b0;
        err_timeout_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (c_req && (!d_req || last_grant_q != SRC_CTRL)) begin
                    state_d      = S_FILL;
                    grant_d      = SRC_CTRL;
                    last_grant_d = SRC_CTRL;
                    len_d        = len_decode(c_len);
                end else if (d_req) begin
                    state_d      = S_FILL;
                    grant_d      = SRC_DATA;
                    last_grant_d = SRC_DATA;
                    len_d        = len_decode(d_len);
                end else begin
                    grant_d = SRC_NONE;
                end
            end
            S_FILL: begin
                if (xfer_s && (byte_cnt_s + 11'd1 == len_q)) begin
                    state_d = S_LOAD;
                end else if (!xfer_s && (tout_cnt_s == TW'(TIMEOUT - 1))) begin
                    state_d       = S_IDLE;
                    grant_d       = SRC_NONE;
                    wr_clear_d    = 1'b1;
                    err_timeout_d = 1'b1;
                end else begin
                    state_d = S_FILL;
                end
            end
            S_LOAD: begin
                // load_1k registers out in the first GUARD cycle, one cycle
                // clear of the last wrreq.
                state_d   = S_GUARD;
                grant_d   = SRC_NONE;
                load_1k_d = 1'b1;
            end
            S_GUARD: begin
                // GUARD lasts the load_1k cycle plus GUARD_CYCLES more.
                if (guard_cnt_s == GW'(GUARD_CYCLES)) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_GUARD;
                end
            end
            default: begin
                state_d = S_IDLE;
                grant_d = SRC_NONE;
            end
        endcase
        if (rst_s) begin
            state_d       = S_IDLE;
            grant_d       = SRC_NONE;
            last_grant_d  = SRC_DATA;
            len_d         = 11'd0;
            load_1k_d     = 1'b0;
            wr_clear_d    = 1'b0;
            err_timeout_d = 1'b0;
        end else begin
            len_d = len_d;
        end
        busy_d = (state_d != S_IDLE);
    end

    // State and registered outputs.
    always_ff @(posedge clock) begin
        state_q       <= state_d;
        grant_q       <= grant_d;
        last_grant_q  <= last_grant_d;
        len_q         <= len_d;
        load_1k_q     <= load_1k_d;
        wr_clear_q    <= wr_clear_d;
        err_timeout_q <= err_timeout_d;
        busy_q        <= busy_d;
    end

    assign grant       = grant_q;
    assign load_1k     = load_1k_q;
    assign wr_clear    = wr_clear_q;
    assign err_timeout = err_timeout_q;
    assign busy        = busy_q;

endmodule
